// File: rtl/chan_cmd_decoder.sv
// chan_cmd_decoder: decodes SPI command bytes into a persistent per-channel
// state register and streams a snapshot of that state back over valid/ready.
module chan_cmd_decoder #(
    parameter int unsigned NUM_CH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cmd_byte,
    input  logic              cmd_valid,
    output logic              busy,
    output logic [NUM_CH-1:0] ch_state,
    output logic [NUM_CH-1:0] toggle_mask,
    output logic              cmd_err,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned TX_BYTES = (NUM_CH + 7) / 8;
    localparam int unsigned SNAP_W   = TX_BYTES * 8;
    localparam int unsigned CNT_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(TX_BYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [CNT_W-1:0]    byte_cnt;
    logic [SNAP_W-1:0]   snap;

    logic [1:0]          opcode;
    logic [5:0]          idx;
    logic                idx_ok;
    logic [NUM_CH-1:0]   onehot;
    logic [NUM_CH-1:0]   next_ch;
    logic                err_c;
    logic                start_rd_c;
    logic [SNAP_W-1:0]   pad_c;
    logic [SNAP_W-1:0]   snap_shift_c;

    assign opcode = cmd_byte[7:6];
    assign idx    = cmd_byte[5:0];

    // Command decode: next channel state, reject flag and read-back request
    always_comb begin
        next_ch      = ch_state;
        err_c        = 1'b0;
        start_rd_c   = 1'b0;
        idx_ok       = (32'(idx) < NUM_CH);
        onehot       = NUM_CH'(1) << idx;
        pad_c        = SNAP_W'(ch_state);
        snap_shift_c = snap >> 8;
        if (cmd_valid) begin
            if (state == SEND) begin
                err_c = 1'b1;
            end else begin
                case (opcode)
                    2'b00: if (idx_ok) next_ch = ch_state ^ onehot;
                           else        err_c   = 1'b1;
                    2'b01: if (idx_ok) next_ch = ch_state | onehot;
                           else        err_c   = 1'b1;
                    2'b10: if (idx_ok) next_ch = ch_state & ~onehot;
                           else        err_c   = 1'b1;
                    default: begin
                        case (idx)
                            6'd0:    next_ch    = '0;
                            6'd1:    next_ch    = '1;
                            6'd2:    start_rd_c = 1'b1;
                            default: err_c      = 1'b1;
                        endcase
                    end
                endcase
            end
        end
    end

    // Channel state, command pulses and read-back FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            snap        <= '0;
            ch_state    <= '0;
            toggle_mask <= '0;
            cmd_err     <= 1'b0;
            busy        <= 1'b0;
            tx_valid    <= 1'b0;
            tx_byte     <= '0;
        end else begin
            ch_state    <= next_ch;
            toggle_mask <= ch_state ^ next_ch;
            cmd_err     <= err_c;
            case (state)
                IDLE: begin
                    if (start_rd_c) begin
                        state    <= SEND;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        snap     <= pad_c;
                        tx_byte  <= pad_c[7:0];
                        byte_cnt <= '0;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            tx_valid <= 1'b0;
                            tx_byte  <= '0;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                            snap     <= snap_shift_c;
                            tx_byte  <= snap_shift_c[7:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
